// File: rtl/dmem_responder.sv
// Single-port data memory that answers RV32I-style load/store requests after a fixed latency.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic            reqWrite,
  input  logic [2:0]      reqF3,
  input  logic [XLEN-1:0] reqAddr,
  input  logic [XLEN-1:0] reqWData,
  output logic            rspValid,
  input  logic            rspReady,
  output logic [XLEN-1:0] rspRData,
  output logic            rspError
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [XLEN-1:0] DEPTH_V  = XLEN'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            write_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            rsp_valid_q;
  logic            rsp_error_q;
  logic [XLEN-1:0] rsp_rdata_q;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0]   word_idx_s;
  logic [XLEN-1:0] rd_word_s;
  logic            range_err_s;
  logic            f3_err_s;
  logic            mis_err_s;
  logic            access_err_s;
  logic            exec_s;
  logic            mem_we_s;
  logic [XLEN-1:0] load_data_d;
  logic [XLEN-1:0] store_word_d;

  // Little-endian extraction of the addressed byte/half with sign or zero extension.
  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] w,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      a);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      3'b010:  r = w;
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // Read-modify-write merge: only the addressed lanes take the new data.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] w,
                                                  input logic [XLEN-1:0] d,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      a);
    logic [XLEN-1:0] m;
    m = w;
    case (f3)
      3'b000: m[{a, 3'b000} +: 8] = d[7:0];
      3'b001: begin
        if (a[1]) begin
          m[31:16] = d[15:0];
        end else begin
          m[15:0] = d[15:0];
        end
      end
      3'b010:  m = d;
      default: m = w;
    endcase
    return m;
  endfunction

  assign word_idx_s  = addr_q[AW+1:2];
  assign rd_word_s   = mem_q[word_idx_s];
  assign range_err_s = ({2'b00, addr_q[XLEN-1:2]} >= DEPTH_V);

  // Legal funct3 encodings differ between loads and stores.
  always_comb begin
    f3_err_s = 1'b0;
    if (write_q) begin
      case (f3_q)
        3'b000, 3'b001, 3'b010: f3_err_s = 1'b0;
        default:                f3_err_s = 1'b1;
      endcase
    end else begin
      case (f3_q)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_err_s = 1'b0;
        default:                                f3_err_s = 1'b1;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_err_s = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign mis_err_s = 1'b0;
`endif

  assign access_err_s = range_err_s | f3_err_s | mis_err_s;
  assign load_data_d  = load_fmt(rd_word_s, f3_q, addr_q[1:0]);
  assign store_word_d = store_merge(rd_word_s, wdata_q, f3_q, addr_q[1:0]);

  // The access executes on the WAIT->RESP edge; a reset in progress suppresses the write.
  assign exec_s   = (state_q == WAIT) && (cnt_q == {CW{1'b0}});
  assign mem_we_s = exec_s && write_q && !access_err_s && !rst;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[word_idx_s] <= store_word_d;
    end
  end

  // Request/response control FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      write_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= {XLEN{1'b0}};
      wdata_q     <= {XLEN{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            write_q <= reqWrite;
            f3_q    <= reqF3;
            addr_q  <= reqAddr;
            wdata_q <= reqWData;
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == {CW{1'b0}}) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= access_err_s;
            rsp_rdata_q <= (write_q || access_err_s) ? {XLEN{1'b0}} : load_data_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (rspReady) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= {CW{1'b0}};
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  assign reqReady = (state_q == IDLE) && !rst;
  assign rspValid = rsp_valid_q;
  assign rspRData = rsp_rdata_q;
  assign rspError = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; expectations are hand-computed constants.
// Honours DMEM_MISALIGN_TRAP_EN for the misaligned-half vector.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqF3;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRData;
  logic        rspError;

  int checks_q;
  int errors_q;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWrite (reqWrite),
    .reqF3    (reqF3),
    .reqAddr  (reqAddr),
    .reqWData (reqWData),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspRData (rspRData),
    .rspError (rspError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One complete transaction; hold > 0 keeps rspReady low for that many cycles in RESP.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int   n;
    logic seen;
    @(negedge clk);
    check_val({tag, "_rdy"}, {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1;
    reqWrite = w;
    reqF3    = f3;
    reqAddr  = a;
    reqWData = d;
    rspReady = (hold == 0);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = rspValid;
    end
    check_val({tag, "_lat"}, 32'(n), 32'd2);
    check_val({tag, "_rd"}, rspRData, exp_rd);
    check_val({tag, "_err"}, {31'd0, rspError}, {31'd0, exp_err});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_val({tag, "_hold_v"}, {31'd0, rspValid}, 32'd1);
        check_val({tag, "_hold_rd"}, rspRData, exp_rd);
        check_val({tag, "_hold_rdy"}, {31'd0, reqReady}, 32'd0);
      end
      rspReady = 1'b1;
    end
    @(posedge clk);
    #1;
    check_val({tag, "_done_v"}, {31'd0, rspValid}, 32'd0);
  endtask

  initial begin
    checks_q = 0;
    errors_q = 0;
    rst      = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqF3    = 3'b000;
    reqAddr  = 32'd0;
    reqWData = 32'd0;
    rspReady = 1'b1;
    #1;
    check_val("rst_rdy", {31'd0, reqReady}, 32'd0);
    check_val("rst_v", {31'd0, rspValid}, 32'd0);
    check_val("rst_rd", rspRData, 32'd0);
    check_val("rst_err", {31'd0, rspError}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst_rdy", {31'd0, reqReady}, 32'd1);

    xact("sw10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    xact("lw10",   1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    xact("lb13",   1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
    xact("lbu13",  1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 0);
    xact("lh12",   1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
    xact("lhu10",  1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 0);
    xact("lb10",   1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    xact("lh11",   1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 0);
    xact("lw11",   1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1, 0);
`else
    xact("lh11",   1'b0, 3'b001, 32'h11, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
    xact("lw11",   1'b0, 3'b010, 32'h11, 32'h0,        32'hDEADBEEF, 1'b0, 0);
`endif
    xact("sb11",   1'b1, 3'b000, 32'h11, 32'hAB000012, 32'h0,        1'b0, 0);
    xact("lw10b",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD12EF, 1'b0, 0);
    xact("sh12",   1'b1, 3'b001, 32'h12, 32'h00005678, 32'h0,        1'b0, 0);
    xact("lw10c",  1'b0, 3'b010, 32'h10, 32'h0,        32'h567812EF, 1'b0, 0);

    xact("lw400",  1'b0, 3'b010, 32'h400, 32'h0,       32'h0,        1'b1, 0);
    xact("lwf3_3", 1'b0, 3'b011, 32'h10,  32'h0,       32'h0,        1'b1, 0);
    xact("ld_f3_6",1'b0, 3'b110, 32'h10,  32'h0,       32'h0,        1'b1, 0);
    xact("sw400",  1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,       1'b1, 0);
    xact("sf3_4",  1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,       1'b1, 0);
    xact("lw10d",  1'b0, 3'b010, 32'h10,  32'h0,       32'h567812EF, 1'b0, 0);
    xact("sw3fc",  1'b1, 3'b010, 32'h3FC, 32'h0BADF00D, 32'h0,       1'b0, 0);
    xact("lw3fc",  1'b0, 3'b010, 32'h3FC, 32'h0,       32'h0BADF00D, 1'b0, 0);

    xact("lwhold", 1'b0, 3'b010, 32'h10,  32'h0,       32'h567812EF, 1'b0, 5);

    xact("sw20",   1'b1, 3'b010, 32'h20,  32'h11223344, 32'h0,       1'b0, 0);
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqF3    = 3'b010;
    reqAddr  = 32'h20;
    reqWData = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("wrst_v", {31'd0, rspValid}, 32'd0);
    check_val("wrst_rdy", {31'd0, reqReady}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("wrst_after_rdy", {31'd0, reqReady}, 32'd1);
    check_val("wrst_after_v", {31'd0, rspValid}, 32'd0);
    xact("lw20",   1'b0, 3'b010, 32'h20,  32'h0,       32'h11223344, 1'b0, 0);
    xact("lw10e",  1'b0, 3'b010, 32'h10,  32'h0,       32'h567812EF, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
